// File: rtl/vedic_dot_acc_pkg.sv
// Shared types and defaults for the vedic dot-product accumulator.
// Holds the FSM encoding and the 2x2 vedic building block.
package vedic_dot_acc_pkg;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int ACC_W_DEF   = 24;
    localparam int MAX_LEN_DEF = 256;
    localparam int CNT_W_DEF   = 9;

    // Urdhva-tiryagbhyam 2x2 cell: vertical and crosswise partials.
    function automatic logic [3:0] vedic2(
        input logic [1:0] a,
        input logic [1:0] b
    );
        logic c;
        logic [3:0] r;
        r[0] = a[0] & b[0];
        r[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
        c    = (a[1] & b[0]) & (a[0] & b[1]);
        r[2] = (a[1] & b[1]) ^ c;
        r[3] = (a[1] & b[1]) & c;
        return r;
    endfunction

endpackage

// File: rtl/vedic_dot_acc_mul.sv
// Combinational 8x8 unsigned vedic multiplier.
// Built from four 4x4 blocks, each built from four 2x2 cells.
module vedic_8x8
    import vedic_dot_acc_pkg::*;
(
    input  logic [7:0]  mul_1,
    input  logic [7:0]  mul_2,
    output logic [15:0] product
);

    function automatic logic [7:0] vedic4(
        input logic [3:0] a,
        input logic [3:0] b
    );
        logic [3:0] q0;
        logic [3:0] q1;
        logic [3:0] q2;
        logic [3:0] q3;
        q0 = vedic2(a[1:0], b[1:0]);
        q1 = vedic2(a[3:2], b[1:0]);
        q2 = vedic2(a[1:0], b[3:2]);
        q3 = vedic2(a[3:2], b[3:2]);
        return {4'b0, q0}
             + {2'b0, q1, 2'b0}
             + {2'b0, q2, 2'b0}
             + {q3, 4'b0};
    endfunction

    logic [7:0] r0;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] r3;

    always_comb begin
        r0 = vedic4(mul_1[3:0], mul_2[3:0]);
        r1 = vedic4(mul_1[7:4], mul_2[3:0]);
        r2 = vedic4(mul_1[3:0], mul_2[7:4]);
        r3 = vedic4(mul_1[7:4], mul_2[7:4]);
        product = {8'b0, r0}
                + {4'b0, r1, 4'b0}
                + {4'b0, r2, 4'b0}
                + {r3, 8'b0};
    end

endmodule

// File: rtl/vedic_dot_acc.sv
// Streaming multiply-accumulate stage: registered operand pair,
// vedic product, accumulator, and a held result port per vector.
module vedic_dot_acc
    import vedic_dot_acc_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    state_t state;
    state_t state_nx;

    logic [7:0]       a_q;
    logic [7:0]       b_q;
    logic             last_q;
    logic             v1;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [15:0]      p;
    logic [ACC_W:0]   sum;
    logic             accept;
    logic             eff_last;

    vedic_8x8 u_mul (
        .mul_1   (a_q),
        .mul_2   (b_q),
        .product (p)
    );

    assign in_ready   = (state == ST_ACC);
    assign out_valid  = (state == ST_DONE);
    assign accept     = in_valid & in_ready;
    assign count_next = count + 1'b1;
    // The element that fills the vector closes it regardless of in_last.
    assign eff_last   = in_last | (count_next == CNT_W'(MAX_LEN));
    assign sum        = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, p};

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_ACC:   if (accept && eff_last) state_nx = ST_FLUSH;
            ST_FLUSH: state_nx = ST_DONE;
            ST_DONE:  if (out_ready) state_nx = ST_ACC;
            default:  state_nx = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACC;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            last_q <= 1'b0;
            v1     <= 1'b0;
        end else begin
            v1 <= accept;
            if (accept) begin
                a_q    <= in_a;
                b_q    <= in_b;
                last_q <= eff_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            ovf       <= 1'b0;
            count     <= '0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (v1 && !last_q) begin
                acc <= sum[ACC_W-1:0];
                ovf <= ovf | sum[ACC_W];
            end else if (v1 && last_q) begin
                out_sum   <= sum[ACC_W-1:0];
                out_ovf   <= ovf | sum[ACC_W];
                out_count <= count;
                acc       <= '0;
                ovf       <= 1'b0;
            end
            // The final pair is counted at accept, so FLUSH sees the full count.
            if (v1 && last_q) begin
                count <= '0;
            end else if (accept) begin
                count <= count_next;
            end
        end
    end

endmodule

// File: tb/tb_vedic_dot_acc.sv
// Bench for vedic_dot_acc: directed scenarios plus a throttled
// random run checked against an a*b reference scoreboard.
module tb_vedic_dot_acc;

    typedef struct {
        logic [23:0] sum;
        int          cnt;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [1:0]      iv;
    logic [1:0]      ir;
    logic [1:0]      il;
    logic [1:0]      ov;
    logic [1:0]      orr;
    logic [1:0]      oovf;
    logic [1:0][7:0] ia;
    logic [1:0][7:0] ib;
    logic [23:0]     sum0;
    logic [15:0]     sum1;
    logic [8:0]      cnt0;
    logic [2:0]      cnt1;

    vedic_dot_acc u0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv[0]),
        .in_ready  (ir[0]),
        .in_a      (ia[0]),
        .in_b      (ib[0]),
        .in_last   (il[0]),
        .out_valid (ov[0]),
        .out_ready (orr[0]),
        .out_sum   (sum0),
        .out_count (cnt0),
        .out_ovf   (oovf[0])
    );

    vedic_dot_acc #(
        .ACC_W   (16),
        .MAX_LEN (4),
        .CNT_W   (3)
    ) u1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv[1]),
        .in_ready  (ir[1]),
        .in_a      (ia[1]),
        .in_b      (ib[1]),
        .in_last   (il[1]),
        .out_valid (ov[1]),
        .out_ready (orr[1]),
        .out_sum   (sum1),
        .out_count (cnt1),
        .out_ovf   (oovf[1])
    );

    int     total = 0;
    int     passed = 0;
    exp_t   q0[$];
    exp_t   q1[$];
    longint m_acc[2];
    int     m_cnt[2];
    int     m_max[2] = '{256, 4};
    int     m_w[2] = '{24, 16};

    function automatic logic [23:0] f_sum(int d);
        if (d == 0) return sum0;
        return {8'b0, sum1};
    endfunction

    function automatic logic [8:0] f_cnt(int d);
        if (d == 0) return cnt0;
        return {6'b0, cnt1};
    endfunction

    // Reference: exact sum of products; wrap and overflow derived from it.
    task automatic model_accept(int d, logic [7:0] a, logic [7:0] b,
                                logic last);
        exp_t   e;
        longint mask;
        m_cnt[d]++;
        m_acc[d] += longint'(a) * longint'(b);
        if (last || m_cnt[d] == m_max[d]) begin
            mask  = (longint'(1) << m_w[d]) - 1;
            e.sum = 24'(m_acc[d] & mask);
            e.cnt = m_cnt[d];
            e.ovf = (m_acc[d] > mask);
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
            m_acc[d] = 0;
            m_cnt[d] = 0;
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rst_n && ov[d] && orr[d]) begin
                total++;
                if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                    $display("FAIL sb_unexpected dut%0d got sum %0d none expected",
                             d, f_sum(d));
                end else begin
                    passed++;
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    total++;
                    if (f_sum(d) !== e.sum)
                        $display("FAIL sb_sum dut%0d got %0d want %0d",
                                 d, f_sum(d), e.sum);
                    else passed++;
                    total++;
                    if (f_cnt(d) !== 9'(e.cnt))
                        $display("FAIL sb_count dut%0d got %0d want %0d",
                                 d, f_cnt(d), e.cnt);
                    else passed++;
                    total++;
                    if (oovf[d] !== e.ovf)
                        $display("FAIL sb_ovf dut%0d got %b want %b",
                                 d, oovf[d], e.ovf);
                    else passed++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int d, logic [7:0] a, logic [7:0] b,
                        logic last, output int waits);
        bit done;
        done  = 1'b0;
        waits = 0;
        iv[d] = 1'b1;
        ia[d] = a;
        ib[d] = b;
        il[d] = last;
        while (!done) begin
            @(negedge clk);
            if (ir[d]) begin
                done = 1'b1;
                model_accept(d, a, b, last);
            end else begin
                waits++;
                if (waits > 300) begin
                    total++;
                    $display("FAIL send_timeout dut%0d got in_ready=0 want 1", d);
                    done = 1'b1;
                end
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
    endtask

    task automatic wait_out(int d, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (ov[d]) ok = 1'b1;
            n++;
        end
        if (!ok) begin
            total++;
            $display("FAIL out_timeout dut%0d got out_valid=0 want 1", d);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        iv    = '0;
        orr   = '0;
        step();
        step();
        @(negedge clk);
        total++;
        if (ir !== 2'b11) $display("FAIL reset_in_ready got %b want 11", ir);
        else passed++;
        total++;
        if (ov !== 2'b00) $display("FAIL reset_out_valid got %b want 00", ov);
        else passed++;
        total++;
        if (sum0 !== 24'd0 || cnt0 !== 9'd0 || oovf[0] !== 1'b0)
            $display("FAIL reset_outputs got %0d/%0d/%b want 0/0/0",
                     sum0, cnt0, oovf[0]);
        else passed++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (ir !== 2'b11 || ov !== 2'b00)
            $display("FAIL reset_release got ir=%b ov=%b want 11/00", ir, ov);
        else passed++;
    endtask

    task automatic test_single();
        int w;
        orr = 2'b11;
        step();
        send(0, 8'd255, 8'd255, 1'b1, w);
        @(negedge clk);
        total++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b0)
            $display("FAIL single_flush got ov=%b ir=%b want 0/0", ov[0], ir[0]);
        else passed++;
        @(negedge clk);
        total++;
        if (ov[0] !== 1'b1) $display("FAIL single_latency got ov=%b want 1", ov[0]);
        else passed++;
        total++;
        if (sum0 !== 24'd65025 || cnt0 !== 9'd1 || oovf[0] !== 1'b0)
            $display("FAIL single_result got %0d/%0d/%b want 65025/1/0",
                     sum0, cnt0, oovf[0]);
        else passed++;
        step();
        @(negedge clk);
        total++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1)
            $display("FAIL single_return got ov=%b ir=%b want 0/1", ov[0], ir[0]);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int w;
        int idle;
        bit seen;
        logic [7:0] av[4] = '{8'd1, 8'd3, 8'd5, 8'd7};
        logic [7:0] bv[4] = '{8'd2, 8'd4, 8'd6, 8'd8};
        step();
        for (int k = 0; k < 4; k++) begin
            send(0, av[k], bv[k], logic'(k == 3), w);
            total++;
            if (w !== 0) $display("FAIL b2b_ready pair%0d got waits %0d want 0", k, w);
            else passed++;
        end
        idle = 0;
        seen = 1'b0;
        @(negedge clk);
        while (!ir[0] && idle < 50) begin
            idle++;
            if (ov[0]) begin
                seen = 1'b1;
                total++;
                if (sum0 !== 24'd100 || cnt0 !== 9'd4)
                    $display("FAIL b2b_result got %0d/%0d want 100/4", sum0, cnt0);
                else passed++;
            end
            @(negedge clk);
        end
        total++;
        if (idle !== 2 || !seen)
            $display("FAIL b2b_gap got idle %0d seen %b want 2/1", idle, seen);
        else passed++;
        step();
        send(0, 8'd1, 8'd1, 1'b1, w);
        repeat (4) step();
    endtask

    task automatic test_ovf();
        int w;
        bit ok;
        send(1, 8'd255, 8'd255, 1'b0, w);
        send(1, 8'd255, 8'd255, 1'b1, w);
        wait_out(1, ok);
        total++;
        if (sum1 !== 16'd64514 || oovf[1] !== 1'b1 || cnt1 !== 3'd2)
            $display("FAIL ovf_wrap got %0d/%b/%0d want 64514/1/2",
                     sum1, oovf[1], cnt1);
        else passed++;
        step();
        send(1, 8'd2, 8'd3, 1'b1, w);
        wait_out(1, ok);
        total++;
        if (sum1 !== 16'd6 || oovf[1] !== 1'b0)
            $display("FAIL ovf_clear got %0d/%b want 6/0", sum1, oovf[1]);
        else passed++;
        step();
    endtask

    task automatic test_maxlen();
        fork
            begin
                int w;
                for (int k = 0; k < 6; k++) begin
                    send(1, 8'd1, 8'd1, 1'b0, w);
                    if (k == 4) begin
                        total++;
                        if (w !== 2)
                            $display("FAIL maxlen_stall got waits %0d want 2", w);
                        else passed++;
                    end
                end
                send(1, 8'd1, 8'd1, 1'b1, w);
            end
            begin
                bit ok;
                wait_out(1, ok);
                total++;
                if (sum1 !== 16'd4 || cnt1 !== 3'd4)
                    $display("FAIL maxlen_first got %0d/%0d want 4/4", sum1, cnt1);
                else passed++;
                step();
                wait_out(1, ok);
                total++;
                if (sum1 !== 16'd3 || cnt1 !== 3'd3)
                    $display("FAIL maxlen_second got %0d/%0d want 3/3", sum1, cnt1);
                else passed++;
            end
        join
        step();
    endtask

    task automatic test_stall();
        int w;
        bit ok;
        logic [23:0] s;
        logic [8:0]  c;
        logic        o;
        orr[0] = 1'b0;
        send(0, 8'd10, 8'd20, 1'b1, w);
        wait_out(0, ok);
        s = sum0;
        c = cnt0;
        o = oovf[0];
        total++;
        if (s !== 24'd200 || c !== 9'd1)
            $display("FAIL stall_result got %0d/%0d want 200/1", s, c);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            step();
            iv[0] = logic'(i % 2);
            ia[0] = 8'($urandom);
            ib[0] = 8'($urandom);
            il[0] = 1'b1;
            @(negedge clk);
            total++;
            if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || sum0 !== s
                || cnt0 !== c || oovf[0] !== o)
                $display("FAIL stall_hold cyc%0d got ov=%b ir=%b sum=%0d want 1/0/%0d",
                         i, ov[0], ir[0], sum0, s);
            else passed++;
        end
        step();
        iv[0]  = 1'b0;
        orr[0] = 1'b1;
        step();
        @(negedge clk);
        total++;
        if (ov[0] !== 1'b0 || q0.size() !== 0)
            $display("FAIL stall_release got ov=%b pending=%0d want 0/0",
                     ov[0], q0.size());
        else passed++;
    endtask

    task automatic test_reset_mid();
        int w;
        bit ok;
        step();
        for (int k = 0; k < 3; k++) send(0, 8'd5, 8'd5, 1'b0, w);
        rst_n = 1'b0;
        #1;
        total++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || sum0 !== 24'd0
            || cnt0 !== 9'd0 || oovf[0] !== 1'b0)
            $display("FAIL rstmid_outputs got ir=%b ov=%b sum=%0d cnt=%0d want 1/0/0/0",
                     ir[0], ov[0], sum0, cnt0);
        else passed++;
        m_acc = '{0, 0};
        m_cnt = '{0, 0};
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        send(0, 8'd2, 8'd2, 1'b1, w);
        wait_out(0, ok);
        total++;
        if (sum0 !== 24'd4 || cnt0 !== 9'd1)
            $display("FAIL rstmid_next got %0d/%0d want 4/1", sum0, cnt0);
        else passed++;
        step();
    endtask

    task automatic test_random();
        bit done0;
        bit done1;
        done0 = 1'b0;
        done1 = 1'b0;
        fork
            begin
                int w;
                int len;
                for (int v = 0; v < 3000; v++) begin
                    if ($urandom_range(0, 3) == 0) step();
                    len = $urandom_range(1, 4);
                    for (int k = 0; k < len; k++)
                        send(0, 8'($urandom), 8'($urandom), logic'(k == len - 1), w);
                end
                done0 = 1'b1;
            end
            begin
                int w;
                int len;
                logic [7:0] a;
                for (int v = 0; v < 3000; v++) begin
                    if ($urandom_range(0, 3) == 0) step();
                    len = $urandom_range(1, 6);
                    for (int k = 0; k < len; k++) begin
                        a = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'($urandom);
                        send(1, a, 8'($urandom_range(200, 255)),
                             logic'(k == len - 1), w);
                    end
                end
                done1 = 1'b1;
            end
            begin
                while (!(done0 && done1)) begin
                    step();
                    orr[0] = ($urandom_range(0, 3) != 0);
                    orr[1] = ($urandom_range(0, 3) != 0);
                end
                orr = 2'b11;
            end
        join
        repeat (20) step();
        total++;
        if (q0.size() !== 0 || q1.size() !== 0 || m_cnt[0] !== 0 || m_cnt[1] !== 0)
            $display("FAIL random_drain got pending %0d/%0d want 0/0",
                     q0.size(), q1.size());
        else passed++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        iv    = '0;
        il    = '0;
        ia    = '0;
        ib    = '0;
        orr   = '0;
        m_acc = '{0, 0};
        m_cnt = '{0, 0};
        test_reset();
        test_single();
        test_back_to_back();
        test_ovf();
        test_maxlen();
        test_stall();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
